// File: rtl/btb_update_queue.sv
// btb_update_queue
//
// Write-side feeder for the branch target buffer. Resolved taken branches
// arrive on two commit lanes (lane 0 is the older instruction) and are
// collected in a small circular FIFO. At most one entry per cycle drains onto
// the single BTB write port, which lets two-wide commit feed a single-write
// BTB. Commit is backpressured when the FIFO runs out of room.
//
// Handshake: a lane transfers an update on a rising edge when
// updk_valid & updk_taken & updk_ready are all high. A lane whose branch is
// not taken (or whose valid is low) transfers nothing. Ready depends only on
// the registered occupancy, so it never depends on valid in the same cycle.
// Raising valid & taken while ready is low is a protocol error; the update
// is dropped and a simulation-only assertion fires.
//
// Optional feature (macro BTB_UQ_MERGE_EN):
//   When defined, an update whose src matches the newest resident entry
//   overwrites that entry's dst instead of allocating a new slot (only while
//   two or more entries are resident, so the head being written to the BTB
//   is never touched). Two same-cycle lanes with equal src collapse into one
//   entry carrying lane 1's dst. When undefined, no src comparators exist.
//
// Parameters:
//   ADDR_LEN  address width of src/dst
//   DEPTH     FIFO entries (power of two, >= 2)
//   PTR_W     log2(DEPTH), head/tail pointer width
//   CNT_W     log2(DEPTH)+1, occupancy counter width
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   upd0_valid/taken/src/dst      commit lane 0 (older)
//   upd1_valid/taken/src/dst      commit lane 1 (younger)
//   upd0_ready, upd1_ready        lane may present an update this cycle
//   btb_we, btb_jmpsrc, btb_jmpdst BTB write port, driven from the head entry
//   count                         current occupancy

module btb_update_queue #(
  parameter int ADDR_LEN = 32,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                upd0_valid,
  input  logic                upd0_taken,
  input  logic [ADDR_LEN-1:0] upd0_src,
  input  logic [ADDR_LEN-1:0] upd0_dst,
  input  logic                upd1_valid,
  input  logic                upd1_taken,
  input  logic [ADDR_LEN-1:0] upd1_src,
  input  logic [ADDR_LEN-1:0] upd1_dst,
  output logic                upd0_ready,
  output logic                upd1_ready,
  output logic                btb_we,
  output logic [ADDR_LEN-1:0] btb_jmpsrc,
  output logic [ADDR_LEN-1:0] btb_jmpdst,
  output logic [CNT_W-1:0]    count
);

  logic [ADDR_LEN-1:0] src_mem [DEPTH];
  logic [ADDR_LEN-1:0] dst_mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count_q;

  logic                q0;
  logic                q1;
  logic                m0;
  logic                m1;
  logic                alloc0;
  logic                alloc1;
  logic                pop;
  logic [1:0]          push_n;
  logic [PTR_W-1:0]    slot1;
  logic [ADDR_LEN-1:0] dst0_eff;

`ifdef BTB_UQ_MERGE_EN
  logic [PTR_W-1:0]    tail_m1;
  logic [ADDR_LEN-1:0] newest_src;
  logic                deep;

  assign tail_m1    = tail - PTR_W'(1);
  assign newest_src = src_mem[tail_m1];
  // With two or more resident entries the newest one is never the head.
  assign deep       = (count_q >= CNT_W'(2));
`endif

  // Ready comes from registered occupancy only; this cycle's pop is not
  // credited, so a push can never collide with a full queue.
  assign upd0_ready = (count_q <= CNT_W'(DEPTH - 1));
  assign upd1_ready = (count_q <= CNT_W'(DEPTH - 2));

  assign q0 = upd0_valid & upd0_taken & upd0_ready;
  assign q1 = upd1_valid & upd1_taken & upd1_ready;

  always_comb begin
    m0 = 1'b0;
    m1 = 1'b0;
`ifdef BTB_UQ_MERGE_EN
    m0 = q0 && deep && (upd0_src == newest_src);
    // When lane 0 also qualifies, it is (or just updated) the newest entry,
    // so lane 1 only needs to compare against lane 0's src.
    m1 = q1 && (q0 ? (upd1_src == upd0_src)
                   : (deep && (upd1_src == newest_src)));
`endif
    alloc0   = q0 && !m0;
    alloc1   = q1 && !m1;
    push_n   = {1'b0, alloc0} + {1'b0, alloc1};
    // Lane 0 writes tail; lane 1 lands right after it only if lane 0
    // actually took a slot.
    slot1    = tail + PTR_W'(alloc0);
    // Lane 1 folding into lane 0's entry makes lane 1's target win.
    dst0_eff = (q0 && m1) ? upd1_dst : upd0_dst;
  end

  assign pop        = (count_q != '0);
  assign btb_we     = pop & ~reset;
  assign btb_jmpsrc = src_mem[head];
  assign btb_jmpdst = dst_mem[head];
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src_mem[i] <= '0;
        dst_mem[i] <= '0;
      end
    end else begin
      if (alloc0) begin
        src_mem[tail] <= upd0_src;
        dst_mem[tail] <= dst0_eff;
      end
      if (alloc1) begin
        src_mem[slot1] <= upd1_src;
        dst_mem[slot1] <= upd1_dst;
      end
`ifdef BTB_UQ_MERGE_EN
      if (m0) begin
        dst_mem[tail_m1] <= dst0_eff;
      end else if (m1 && !q0) begin
        dst_mem[tail_m1] <= upd1_dst;
      end
`endif
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      tail    <= tail + PTR_W'(push_n);
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

`ifndef SYNTHESIS
  a_lane0_overflow : assert property (@(posedge clk) disable iff (reset)
    !(upd0_valid && upd0_taken && !upd0_ready))
    else $error("btb_update_queue: lane 0 update while not ready");
  a_lane1_overflow : assert property (@(posedge clk) disable iff (reset)
    !(upd1_valid && upd1_taken && !upd1_ready))
    else $error("btb_update_queue: lane 1 update while not ready");
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue. The expected BTB write stream is
// held in exp_q; each driven update is appended (or folded into the newest
// entry when the merge feature is built in) and each BTB write pops and
// compares the oldest expectation.

module tb_btb_update_queue;

  localparam int AL    = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int W     = 2 * AL;
`ifdef BTB_UQ_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             upd0_valid, upd0_taken, upd1_valid, upd1_taken;
  logic [AL-1:0]    upd0_src, upd0_dst, upd1_src, upd1_dst;
  logic             upd0_ready, upd1_ready, btb_we;
  logic [AL-1:0]    btb_jmpsrc, btb_jmpdst;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;
  int writes = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  btb_update_queue #(.ADDR_LEN(AL), .DEPTH(DEPTH), .PTR_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .upd0_valid(upd0_valid), .upd0_taken(upd0_taken),
    .upd0_src(upd0_src), .upd0_dst(upd0_dst),
    .upd1_valid(upd1_valid), .upd1_taken(upd1_taken),
    .upd1_src(upd1_src), .upd1_dst(upd1_dst),
    .upd0_ready(upd0_ready), .upd1_ready(upd1_ready),
    .btb_we(btb_we), .btb_jmpsrc(btb_jmpsrc), .btb_jmpdst(btb_jmpdst),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_we;
      logic [W-1:0] got;
      exp_we = !reset && (exp_q.size() != 0);
      checks++;
      if (btb_we !== exp_we) begin
        errors++;
        $display("FAIL btb_we: got %b want %b (t=%0t)", btb_we, exp_we, $time);
      end
      if (exp_we) begin
        got = {btb_jmpsrc, btb_jmpdst};
        checks++;
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL btb_write: got src=%h dst=%h want src=%h dst=%h",
                   btb_jmpsrc, btb_jmpdst, exp_q[0][W-1:AL], exp_q[0][AL-1:0]);
        end
        void'(exp_q.pop_front());
        writes++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    upd0_valid = 1'b0; upd0_taken = 1'b0; upd0_src = '0; upd0_dst = '0;
    upd1_valid = 1'b0; upd1_taken = 1'b0; upd1_src = '0; upd1_dst = '0;
  endtask

  // Called just after a rising edge; applies one cycle of lane stimulus,
  // updates the expected stream and returns just after the next edge.
  // Lanes are only presented when the model says there is room.
  task automatic drive(input logic v0, input logic t0,
                       input logic [AL-1:0] s0, input logic [AL-1:0] d0,
                       input logic v1, input logic t1,
                       input logic [AL-1:0] s1, input logic [AL-1:0] d1);
    int pre;
    logic q0, q1;
    logic [W-1:0] new_q[$];
    logic [W-1:0] last;
    int idx;
    pre = exp_q.size();
    upd0_valid = v0 && (pre <= DEPTH - 1); upd0_taken = t0;
    upd0_src = s0; upd0_dst = d0;
    upd1_valid = v1 && (pre <= DEPTH - 2); upd1_taken = t1;
    upd1_src = s1; upd1_dst = d1;
    q0 = upd0_valid && t0;
    q1 = upd1_valid && t1;
    if (q0) begin
      idx = exp_q.size() - 1;
      if (MERGE && pre >= 2 && exp_q[idx][W-1:AL] == s0)
        exp_q[idx] = {s0, d0};
      else
        new_q.push_back({s0, d0});
    end
    if (q1) begin
      if (new_q.size() != 0) last = new_q[new_q.size() - 1];
      else if (exp_q.size() != 0) last = exp_q[exp_q.size() - 1];
      else last = '0;
      if (MERGE && (q0 || pre >= 2) && last[W-1:AL] == s1) begin
        if (new_q.size() != 0) new_q[new_q.size() - 1] = {s1, d1};
        else exp_q[exp_q.size() - 1] = {s1, d1};
      end else begin
        new_q.push_back({s1, d1});
      end
    end
    @(posedge clk);
    foreach (new_q[i]) exp_q.push_back(new_q[i]);
    #1;
    set_idle();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    checks++;
    if (count !== 4'd0 || btb_we !== 1'b0) begin
      errors++; $display("FAIL reset_state: got count=%0d we=%b want 0 0", count, btb_we);
    end
    checks++;
    if (btb_jmpsrc !== '0 || btb_jmpdst !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h want 0/0", btb_jmpsrc, btb_jmpdst);
    end
    checks++;
    if (upd0_ready !== 1'b1 || upd1_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b%b want 11", upd0_ready, upd1_ready);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, '0, '0);
    checks++;
    if (btb_we !== 1'b1 || btb_jmpsrc !== 32'h100 || btb_jmpdst !== 32'h200 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_flow: got we=%b %h/%h count=%0d want 1 100/200 1",
               btb_we, btb_jmpsrc, btb_jmpdst, count);
    end
    idle();
    checks++;
    if (btb_we !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL single_drain: got we=%b count=%0d want 0 0", btb_we, count);
    end
  endtask

  task automatic test_dual();
    drive(1'b1, 1'b1, 32'h10, 32'h40, 1'b1, 1'b1, 32'h14, 32'h80);
    checks++;
    if (count !== 4'd2 || btb_jmpsrc !== 32'h10 || btb_jmpdst !== 32'h40) begin
      errors++; $display("FAIL dual_first: got count=%0d %h/%h want 2 10/40", count, btb_jmpsrc, btb_jmpdst);
    end
    idle();
    checks++;
    if (count !== 4'd1 || btb_jmpsrc !== 32'h14 || btb_jmpdst !== 32'h80) begin
      errors++; $display("FAIL dual_second: got count=%0d %h/%h want 1 14/80", count, btb_jmpsrc, btb_jmpdst);
    end
    idle();
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL dual_empty: got count=%0d want 0", count);
    end
  endtask

  task automatic test_filter();
    drive(1'b1, 1'b0, 32'h20, 32'h60, 1'b1, 1'b1, 32'h30, 32'h90);
    checks++;
    if (count !== 4'd1 || btb_jmpsrc !== 32'h30 || btb_jmpdst !== 32'h90) begin
      errors++; $display("FAIL filter_taken: got count=%0d %h/%h want 1 30/90", count, btb_jmpsrc, btb_jmpdst);
    end
    idle();
    drive(1'b0, 1'b1, 32'h24, 32'h64, 1'b0, 1'b1, 32'h28, 32'h68);
    checks++;
    if (count !== 4'd0 || btb_we !== 1'b0) begin
      errors++; $display("FAIL filter_invalid: got count=%0d we=%b want 0 0", count, btb_we);
    end
  endtask

  task automatic test_full();
    int w0;
    w0 = writes;
    for (int n = 0; n < 12; n++) begin
      drive(1'b1, 1'b1, 32'h1000 + 8 * n, 32'h5000 + n, 1'b1, 1'b1, 32'h1004 + 8 * n, 32'h6000 + n);
      checks++;
      if (count !== CNT_W'(exp_q.size())) begin
        errors++; $display("FAIL full_count[%0d]: got %0d want %0d", n, count, exp_q.size());
      end
      checks++;
      if (upd0_ready !== (exp_q.size() <= DEPTH - 1) || upd1_ready !== (exp_q.size() <= DEPTH - 2)) begin
        errors++; $display("FAIL full_ready[%0d]: got %b%b at count %0d", n, upd0_ready, upd1_ready, exp_q.size());
      end
    end
    checks++;
    if (count !== 4'd7 || upd0_ready !== 1'b1 || upd1_ready !== 1'b0) begin
      errors++; $display("FAIL full_steady: got count=%0d ready=%b%b want 7 10", count, upd0_ready, upd1_ready);
    end
    for (int n = 0; n < 20 && (exp_q.size() != 0 || count != 0); n++) idle();
    checks++;
    if (writes - w0 !== 18 || count !== 4'd0) begin
      errors++; $display("FAIL full_drain: got writes=%0d count=%0d want 18 0", writes - w0, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 4; n++)
      drive(1'b1, 1'b1, 32'h700 + 8 * n, 32'h800 + n, 1'b1, 1'b1, 32'h704 + 8 * n, 32'h900 + n);
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("FAIL mid_fill: got count=%0d want 5", count);
    end
    do_reset();
    checks++;
    if (count !== 4'd0 || btb_we !== 1'b0 || upd0_ready !== 1'b1 || upd1_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got count=%0d we=%b ready=%b%b want 0 0 11",
                         count, btb_we, upd0_ready, upd1_ready);
    end
    repeat (3) idle();
  endtask

  task automatic test_merge();
    drive(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 32'h44, 32'h2);
    drive(1'b1, 1'b1, 32'h48, 32'h3, 1'b1, 1'b1, 32'h50, 32'h4);
    checks++;
    if (count !== 4'd3) begin
      errors++; $display("FAIL merge_setup: got count=%0d want 3", count);
    end
    drive(1'b1, 1'b1, 32'h50, 32'hA0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (count !== (MERGE ? 4'd2 : 4'd3)) begin
      errors++; $display("FAIL merge_newest: got count=%0d want %0d", count, MERGE ? 2 : 3);
    end
    drive(1'b1, 1'b1, 32'h60, 32'hB1, 1'b1, 1'b1, 32'h60, 32'hB2);
    checks++;
    if (count !== CNT_W'(exp_q.size())) begin
      errors++; $display("FAIL merge_pair: got count=%0d want %0d", count, exp_q.size());
    end
    for (int n = 0; n < 12 && (exp_q.size() != 0 || count != 0); n++) idle();
    checks++;
    if (count !== 4'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL merge_drain: got count=%0d pending=%0d want 0 0", count, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            32'h200 + 4 * $urandom_range(0, 3), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            32'h200 + 4 * $urandom_range(0, 3), $urandom);
      checks++;
      if (count !== CNT_W'(exp_q.size())) begin
        errors++; $display("FAIL random_count[%0d]: got %0d want %0d", n, count, exp_q.size());
      end
    end
    for (int n = 0; n < 12 && (exp_q.size() != 0 || count != 0); n++) idle();
    checks++;
    if (count !== 4'd0 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got count=%0d pending=%0d want 0 0", count, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_single();
    test_dual();
    test_filter();
    test_full();
    test_reset_mid();
    test_merge();
    test_random();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
